// File: rtl/pmu_pkg.sv
// -----------------------------------------------------------------------------
// pmu_pkg
// Shared definitions for the always-on power-sequencing controller.
// Also imported by reg_ctrl, which decodes pmu_state for the status register.
//   pmu_state_e     : 3-bit state codes as seen on pmu_state
//   PMU_RST_DLY_DEF : default clock-enable to reset-release spacing (cycles)
//   pmu_out_t       : bundle of the four Moore control outputs
//   pmu_decode()    : state -> control outputs
// -----------------------------------------------------------------------------
package pmu_pkg;

    localparam int PMU_RST_DLY_DEF = 4;

    typedef enum logic [2:0] {
        PMU_SLEEP   = 3'd0,
        PMU_OSC_ON  = 3'd1,
        PMU_CLK_ON  = 3'd2,
        PMU_ACTIVE  = 3'd3,
        PMU_RST_ON  = 3'd4,
        PMU_CLK_OFF = 3'd5
    } pmu_state_e;

    typedef struct packed {
        logic osc13m_en;
        logic clk_en;
        logic shut_rstn;
        logic pmu_busy;
    } pmu_out_t;

    // Codes 6/7 decode to all-zero, matching SLEEP.
    function automatic pmu_out_t pmu_decode(input pmu_state_e s);
        pmu_out_t o;
        o = '0;
        case (s)
            PMU_OSC_ON:  begin o.osc13m_en = 1'b1; o.pmu_busy = 1'b1; end
            PMU_CLK_ON:  begin o.osc13m_en = 1'b1; o.clk_en = 1'b1; o.pmu_busy = 1'b1; end
            PMU_ACTIVE:  begin o.osc13m_en = 1'b1; o.clk_en = 1'b1; o.shut_rstn = 1'b1; end
            PMU_RST_ON:  begin o.osc13m_en = 1'b1; o.clk_en = 1'b1; o.pmu_busy = 1'b1; end
            PMU_CLK_OFF: begin o.osc13m_en = 1'b1; o.pmu_busy = 1'b1; end
            default:     o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pmu_ctrl.sv
// -----------------------------------------------------------------------------
// pmu_ctrl
// Always-on power sequencer (32 kHz domain). Power-up order: oscillator enable,
// settle wait, shut-domain clock enable, reset release. Power-down reverses it.
// Ports:
//   clk_32k         always-on clock (only clock)
//   rst_32k_alon_n  synchronous active-low reset
//   rg_pmu_en       block enable (synchronized)
//   rg_osc_settle   oscillator settle time in clk_32k cycles
//   wake_req        wake request (synchronized)
//   sleep_req       sleep request (synchronized)
//   osc13m_en       13 MHz oscillator enable
//   clk_en          shut-domain clock enable
//   shut_rstn       shut-domain reset, active-low
//   pmu_busy        sequence in progress
//   pmu_state       current state code
// -----------------------------------------------------------------------------
module pmu_ctrl
    import pmu_pkg::*;
#(
    parameter int SETTLE_W = 8,
    parameter int RST_DLY  = PMU_RST_DLY_DEF
) (
    input  logic                clk_32k,
    input  logic                rst_32k_alon_n,
    input  logic                rg_pmu_en,
    input  logic [SETTLE_W-1:0] rg_osc_settle,
    input  logic                wake_req,
    input  logic                sleep_req,
    output logic                osc13m_en,
    output logic                clk_en,
    output logic                shut_rstn,
    output logic                pmu_busy,
    output logic [2:0]          pmu_state
);

    localparam int CNT_W = (SETTLE_W > $clog2(RST_DLY)) ? SETTLE_W : $clog2(RST_DLY);
    localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(RST_DLY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    pmu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wake_pend_q, wake_pend_d;
    logic             sleep_pend_q, sleep_pend_d;
    pmu_out_t         out_q;

    // Counts are only ever loaded on state entry and stop at zero, so the
    // counter cannot wrap.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wake_pend_d  = wake_pend_q;
        sleep_pend_d = sleep_pend_q;
        case (state_q)
            PMU_SLEEP: begin
                // A parked wake waits here until the block is enabled.
                if ((wake_req || wake_pend_q) && rg_pmu_en) begin
                    state_d     = PMU_OSC_ON;
                    cnt_d       = CNT_W'(rg_osc_settle);
                    wake_pend_d = 1'b0;
                end
            end
            PMU_OSC_ON: begin
                if (sleep_req) sleep_pend_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = PMU_CLK_ON;
                    cnt_d   = DLY_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            PMU_CLK_ON: begin
                if (sleep_req) sleep_pend_d = 1'b1;
                if (cnt_q == '0) state_d = PMU_ACTIVE;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            PMU_ACTIVE: begin
                // Sleep has priority; a wake in ACTIVE needs no action.
                if (sleep_req || sleep_pend_q || !rg_pmu_en) begin
                    state_d      = PMU_RST_ON;
                    cnt_d        = DLY_LOAD;
                    sleep_pend_d = 1'b0;
                end
            end
            PMU_RST_ON: begin
                if (wake_req) wake_pend_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = PMU_CLK_OFF;
                    cnt_d   = DLY_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            PMU_CLK_OFF: begin
                if (wake_req) wake_pend_d = 1'b1;
                if (cnt_q == '0) state_d = PMU_SLEEP;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            default: state_d = PMU_SLEEP;
        endcase
    end

    // Outputs are registered from the next state so they switch on the same
    // edge as the state code, with no path from inputs to outputs.
    always_ff @(posedge clk_32k) begin
        if (!rst_32k_alon_n) begin
            state_q      <= PMU_SLEEP;
            cnt_q        <= '0;
            wake_pend_q  <= 1'b0;
            sleep_pend_q <= 1'b0;
            out_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wake_pend_q  <= wake_pend_d;
            sleep_pend_q <= sleep_pend_d;
            out_q        <= pmu_decode(state_d);
        end
    end

    assign osc13m_en = out_q.osc13m_en;
    assign clk_en    = out_q.clk_en;
    assign shut_rstn = out_q.shut_rstn;
    assign pmu_busy  = out_q.pmu_busy;
    assign pmu_state = state_q;

endmodule

// File: tb/tb_pmu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pmu_ctrl
// Self-checking bench for pmu_ctrl: a vector table for the nominal power
// cycle, hand-written corner sequences, and a randomized run against a
// timeline-based reference model.
// -----------------------------------------------------------------------------
module tb_pmu_ctrl;
    import pmu_pkg::*;

    localparam int SW = 8;
    localparam int RD = 4;

    logic          clk_32k = 1'b0;
    logic          rst_n;
    logic          en;
    logic          wake;
    logic          slp;
    logic [SW-1:0] settle;
    logic          osc;
    logic          cen;
    logic          srstn;
    logic          busy;
    logic [2:0]    st;

    int checks = 0;
    int errors = 0;
    int now    = 0;

    always #15 clk_32k = ~clk_32k;

    pmu_ctrl #(.SETTLE_W(SW), .RST_DLY(RD)) dut (
        .clk_32k        (clk_32k),
        .rst_32k_alon_n (rst_n),
        .rg_pmu_en      (en),
        .rg_osc_settle  (settle),
        .wake_req       (wake),
        .sleep_req      (slp),
        .osc13m_en      (osc),
        .clk_en         (cen),
        .shut_rstn      (srstn),
        .pmu_busy       (busy),
        .pmu_state      (st)
    );

    // Reference model: tracks the current phase and the cycle it started,
    // and derives outputs from elapsed time using the documented durations
    // (oscillator-only S+1 cycles, then RD cycles per clock/reset step).
    typedef enum int {M_IDLE, M_UP, M_ON, M_DOWN} mmode_e;
    mmode_e m_mode = M_IDLE;
    int     m_t0   = 0;
    int     m_s    = 0;
    bit     m_wp   = 1'b0;
    bit     m_sp   = 1'b0;

    task automatic model_edge();
        if (!rst_n) begin
            m_mode = M_IDLE;
            m_wp   = 1'b0;
            m_sp   = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: if ((wake || m_wp) && en) begin
                    m_mode = M_UP;
                    m_t0   = now;
                    m_s    = int'(settle);
                    m_wp   = 1'b0;
                end
                M_UP: begin
                    if (slp) m_sp = 1'b1;
                    if (now == m_t0 + m_s + 1 + RD) m_mode = M_ON;
                end
                M_ON: if (slp || m_sp || !en) begin
                    m_mode = M_DOWN;
                    m_t0   = now;
                    m_sp   = 1'b0;
                end
                M_DOWN: begin
                    if (wake) m_wp = 1'b1;
                    if (now == m_t0 + 2 * RD) m_mode = M_IDLE;
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    // {osc13m_en, clk_en, shut_rstn, pmu_busy, pmu_state}
    function automatic logic [6:0] model_exp();
        int k;
        k = now - m_t0;
        case (m_mode)
            M_UP:    return (k <= m_s) ? {4'b1001, 3'd1} : {4'b1101, 3'd2};
            M_ON:    return {4'b1110, 3'd3};
            M_DOWN:  return (k < RD) ? {4'b1101, 3'd4} : {4'b1001, 3'd5};
            default: return 7'd0;
        endcase
    endfunction

    function automatic logic [6:0] dut_vec();
        return {osc, cen, srstn, busy, st};
    endfunction

    task automatic step();
        logic [6:0] e;
        @(posedge clk_32k);
        now++;
        model_edge();
        #1;
        e = model_exp();
        checks++;
        if (dut_vec() !== e) begin
            errors++;
            $display("FAIL model cyc=%0d got=%b exp=%b", now, dut_vec(), e);
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Step until pmu_state == target, bounded; a timeout fails the check.
    task automatic wait_state(input string name, input int target, input int max, output int n);
        n = 0;
        while (int'(st) != target && n < max) begin
            step();
            n++;
        end
        chk(name, int'(st), target);
    endtask

    task automatic power_up(input string name);
        int n;
        wake = 1'b1;
        step();
        wake = 1'b0;
        wait_state(name, 3, 400, n);
    endtask

    task automatic power_down(input string name);
        int n;
        slp = 1'b1;
        step();
        slp = 1'b0;
        wait_state(name, 0, 100, n);
    endtask

    typedef struct {
        bit         wake;
        bit         sleep;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[29];
    int   stv[0:31];

    initial begin
        int n;
        int c;
        int t_up;

        // Nominal power cycle from SLEEP: wake at edge 0, sleep at edge 20.
        for (int i = 0; i < 29; i++) begin
            c = i + 1;
            vecs[i].wake  = (i == 0);
            vecs[i].sleep = (i == 20);
            if (c <= 11)      vecs[i].exp = {4'b1001, 3'd1};
            else if (c <= 15) vecs[i].exp = {4'b1101, 3'd2};
            else if (c <= 20) vecs[i].exp = {4'b1110, 3'd3};
            else if (c <= 24) vecs[i].exp = {4'b1101, 3'd4};
            else if (c <= 28) vecs[i].exp = {4'b1001, 3'd5};
            else              vecs[i].exp = 7'd0;
        end

        rst_n  = 1'b0;
        en     = 1'b1;
        wake   = 1'b0;
        slp    = 1'b0;
        settle = SW'(10);
        step();
        step();
        chk("rst_osc", int'(osc), 0);
        chk("rst_clk_en", int'(cen), 0);
        chk("rst_shut_rstn", int'(srstn), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_state", int'(st), 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 29; i++) begin
            wake = vecs[i].wake;
            slp  = vecs[i].sleep;
            step();
            chk($sformatf("vec%0d", i), int'(dut_vec()), int'(vecs[i].exp));
        end
        wake = 1'b0;
        slp  = 1'b0;
        $display("nominal power cycle: %0d vectors applied", 29);

        // Sleep pulse during power-up is deferred until ACTIVE.
        for (int k = 0; k < 32; k++) stv[k] = -1;
        wake = 1'b1;
        step();
        wake = 1'b0;
        stv[1] = int'(st);
        for (int k = 2; k <= 26; k++) begin
            slp = (k == 6);
            step();
            stv[k] = int'(st);
        end
        slp = 1'b0;
        chk("pend_sleep_c5", stv[5], 1);
        chk("pend_sleep_c15", stv[15], 2);
        chk("pend_sleep_c16", stv[16], 3);
        chk("pend_sleep_c17", stv[17], 4);
        chk("pend_sleep_c24", stv[24], 5);
        chk("pend_sleep_c25", stv[25], 0);
        $display("sleep pending during power-up: active at 16, sleep at 25");

        // Wake during CLK_OFF: finish power-down, one SLEEP cycle, full power-up.
        power_up("wake_clkoff_up");
        slp = 1'b1;
        step();
        slp = 1'b0;
        repeat (4) step();
        chk("wake_clkoff_t5", int'(st), 5);
        wake = 1'b1;
        step();
        wake = 1'b0;
        repeat (3) step();
        chk("wake_clkoff_t9", int'(st), 0);
        step();
        chk("wake_clkoff_t10", int'(st), 1);
        wait_state("wake_clkoff_active", 3, 100, t_up);
        chk("wake_clkoff_uplen", t_up, 15);
        $display("wake during CLK_OFF: re-powered in %0d cycles", t_up);

        // Simultaneous wake and sleep in ACTIVE: sleep wins, wake is dropped.
        wake = 1'b1;
        slp  = 1'b1;
        step();
        wake = 1'b0;
        slp  = 1'b0;
        chk("simul_state", int'(st), 4);
        chk("simul_shut_rstn", int'(srstn), 0);
        wait_state("simul_sleep", 0, 100, n);
        repeat (3) step();
        chk("simul_stay_sleep", int'(st), 0);
        $display("simultaneous wake+sleep in ACTIVE: powered down");

        // Zero settle: OSC_ON lasts one cycle.
        settle = SW'(0);
        wake = 1'b1;
        step();
        wake = 1'b0;
        chk("settle0_osc", int'(st), 1);
        step();
        chk("settle0_clk_on", int'(st), 2);
        chk("settle0_clk_en", int'(cen), 1);
        wait_state("settle0_active", 3, 20, n);
        settle = SW'(10);
        power_down("settle0_down");
        $display("settle=0: single OSC_ON cycle");

        // Disable in ACTIVE powers down; a wake parked meanwhile waits for enable.
        power_up("dis_up");
        en = 1'b0;
        step();
        chk("dis_rst_on", int'(st), 4);
        wake = 1'b1;
        step();
        wake = 1'b0;
        wait_state("dis_sleep", 0, 100, n);
        repeat (3) step();
        chk("dis_hold_sleep", int'(st), 0);
        en = 1'b1;
        step();
        chk("dis_pend_wake", int'(st), 1);
        wait_state("dis_reup", 3, 100, n);
        power_down("dis_down");
        $display("rg_pmu_en=0: power-down, pending wake held until enable");

        // Reset in CLK_ON drops everything on that edge.
        wake = 1'b1;
        step();
        wake = 1'b0;
        wait_state("rst_mid_clk_on", 2, 100, n);
        rst_n = 1'b0;
        step();
        chk("rst_mid_vec", int'(dut_vec()), 0);
        rst_n = 1'b1;
        repeat (5) step();
        chk("rst_mid_stay", int'(st), 0);
        wake = 1'b1;
        step();
        wake = 1'b0;
        chk("rst_mid_rewake", int'(st), 1);
        wait_state("rst_mid_active", 3, 100, n);
        $display("reset in CLK_ON: outputs cleared, new wake required");

        // Randomized run against the reference model.
        for (int i = 0; i < 4000; i++) begin
            mmode_e prev;
            wake  = ($urandom_range(0, 19) == 0);
            slp   = ($urandom_range(0, 24) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 29) == 0) settle = SW'($urandom_range(0, 12));
            prev = m_mode;
            step();
            if (prev != M_UP && m_mode == M_UP)
                $display("random cyc=%0d power-up settle=%0d", now, m_s);
            else if (prev != M_DOWN && m_mode == M_DOWN)
                $display("random cyc=%0d power-down", now);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
